// File: rtl/j1a_bus_responder_if.sv
// Shared instruction/data bus bundle for the J1A memory responder.
// Signal names keep the responder-side _i/_o directions.
interface j1a_bus_responder_if;
  logic [15:1] ins_adr_i;
  logic [15:0] ins_dat_o;
  logic [15:1] dat_adr_i;
  logic [15:0] dat_dat_i;
  logic [15:0] dat_dat_o;
  logic        dat_we_i;
  logic        ins_cyc_i;
  logic        shr_stb_i;
  logic        shr_ack_o;

  modport slave (
    input  ins_adr_i, dat_adr_i, dat_dat_i, dat_we_i, ins_cyc_i, shr_stb_i,
    output ins_dat_o, dat_dat_o, shr_ack_o
  );

  modport master (
    output ins_adr_i, dat_adr_i, dat_dat_i, dat_we_i, ins_cyc_i, shr_stb_i,
    input  ins_dat_o, dat_dat_o, shr_ack_o
  );
endinterface

// File: rtl/j1a_bus_responder.sv
// Wait-stated single-memory responder serving the J1A instruction and data buses in lock-step.
// Define J1A_RESP_WRITE_EN to enable data writes; otherwise the memory is read-only.
module j1a_bus_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic               sys_clk_i,
  input logic               sys_res_i,
  j1a_bus_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q;
  logic [DW-1:0]         ins_dat_q, dat_dat_q;
  logic [DW-1:0]         mem_q [DEPTH];
  logic                  req_c, load_c, wr_en_c;
  logic [DEPTH_LOG2-1:0] ins_idx_c, dat_idx_c;
  logic                  unused_c;

  assign req_c     = bus.ins_cyc_i & bus.shr_stb_i;
  assign ins_idx_c = bus.ins_adr_i[DEPTH_LOG2:1];
  assign dat_idx_c = bus.dat_adr_i[DEPTH_LOG2:1];
  // Upper address bits alias; in the read-only build the write inputs are ignored.
  assign unused_c  = ^{bus.ins_adr_i, bus.dat_adr_i, bus.dat_dat_i, bus.dat_we_i};

  // Next-state logic; load_c marks the edge that enters ACK and captures read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            load_c  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!req_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACK;
          cnt_d   = '0;
          load_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_res_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ins_dat_q <= '0;
      dat_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == S_ACK);
      if (load_c) begin
        ins_dat_q <= mem_q[ins_idx_c];
        dat_dat_q <= mem_q[dat_idx_c];
      end
    end
  end

  // Write lands on the edge closing ACK, after the read was captured (read-before-write).
`ifdef J1A_RESP_WRITE_EN
  assign wr_en_c = (state_q == S_ACK) & req_c & bus.dat_we_i & ~sys_res_i;
`else
  assign wr_en_c = 1'b0;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (wr_en_c) begin
      mem_q[dat_idx_c] <= bus.dat_dat_i;
    end
  end

  assign bus.shr_ack_o = ack_q;
  assign bus.ins_dat_o = ins_dat_q;
  assign bus.dat_dat_o = dat_dat_q;
endmodule

// File: tb/tb_j1a_bus_responder.sv
// Directed bench for j1a_bus_responder: WAIT_STATES=1 and WAIT_STATES=3 instances with a scoreboard.
module tb_j1a_bus_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  j1a_bus_responder_if b1 ();
  j1a_bus_responder_if b3 ();

  j1a_bus_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut (
    .sys_clk_i(clk), .sys_res_i(rst), .bus(b1)
  );
  j1a_bus_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut3 (
    .sys_clk_i(clk), .sys_res_i(rst), .bus(b3)
  );

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] dat;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] mem1 [1024];
  logic [15:0] mem3 [1024];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [15:0] pat(input int i);
    if (i == 5) return 16'h8123;
    if (i == 7) return 16'h1234;
    return 16'(i * 40503 + 16'h1357);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [15:1] ia, input logic [15:1] da,
                       input logic we, input logic [15:0] wd, input logic req);
    if (sel) begin
      b3.ins_adr_i = ia; b3.dat_adr_i = da; b3.dat_we_i = we; b3.dat_dat_i = wd;
      b3.ins_cyc_i = req; b3.shr_stb_i = req;
    end else begin
      b1.ins_adr_i = ia; b1.dat_adr_i = da; b1.dat_we_i = we; b1.dat_dat_i = wd;
      b1.ins_cyc_i = req; b1.shr_stb_i = req;
    end
  endtask

  function automatic logic [2:0] ack_of(input bit sel);
    return sel ? {b3.shr_ack_o, 2'b00} : {b1.shr_ack_o, 2'b00};
  endfunction

  function automatic logic [31:0] rd_of(input bit sel);
    return sel ? {b3.ins_dat_o, b3.dat_dat_o} : {b1.ins_dat_o, b1.dat_dat_o};
  endfunction

  // One transfer, called at a negedge; drop=1 releases cyc/stb during the ACK cycle.
  task automatic xfer(input bit sel, input logic [15:1] ia, input logic [15:1] da,
                      input logic we, input logic [15:0] wd, input bit drop);
    exp_t e;
    exp_t got;
    int   lat;
    int   wmax;
    bit   seen;
    wmax  = sel ? 3 : 1;
    e.ins = sel ? mem3[ia[10:1]] : mem1[ia[10:1]];
    e.dat = sel ? mem3[da[10:1]] : mem1[da[10:1]];
    sb_q.push_back(e);
`ifdef J1A_RESP_WRITE_EN
    if (we && !drop) begin
      if (sel) mem3[da[10:1]] = wd;
      else     mem1[da[10:1]] = wd;
    end
`endif
    drive(sel, ia, da, we, wd, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = ack_of(sel)[2];
    end
    chk("ack_latency", 32'(lat), 32'(wmax + 1));
    if (seen && sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk("rd_data", rd_of(sel), {got.ins, got.dat});
    end
    if (drop) drive(sel, ia, da, we, wd, 1'b0);
    @(negedge clk);
    chk("ack_pulse", 32'(ack_of(sel)), 32'd0);
    chk("rd_hold", rd_of(sel), {e.ins, e.dat});
    drive(sel, ia, da, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 16'h0000, 1'b0);
    drive(1'b1, '0, '0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = pat(i);
      mem3[i] = pat(i);
      dut.mem_q[i]  = pat(i);
      dut3.mem_q[i] = pat(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_ack1", 32'(b1.shr_ack_o), 32'd0);
    chk("rst_dat1", rd_of(1'b0), 32'd0);
    chk("rst_ack3", 32'(b3.shr_ack_o), 32'd0);
    chk("rst_dat3", rd_of(1'b1), 32'd0);

    // Idle with cyc/stb low: no ACK, outputs stay zero.
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle", {15'd0, b1.shr_ack_o, b1.ins_dat_o}, 32'd0);
    end

    xfer(1'b0, 15'd5, 15'd5, 1'b0, 16'h0000, 1'b0);
    xfer(1'b0, 15'd7, 15'd7, 1'b1, 16'hBEEF, 1'b0);
    xfer(1'b0, 15'd7, 15'd7, 1'b0, 16'h0000, 1'b0);
    xfer(1'b0, 15'h0405, 15'h0406, 1'b0, 16'h0000, 1'b0);
    xfer(1'b0, 15'd13, 15'd13, 1'b1, 16'h5555, 1'b1);
    xfer(1'b0, 15'd13, 15'd13, 1'b0, 16'h0000, 1'b0);

    for (int k = 0; k < 8; k++) begin
      xfer(1'b0, 15'($urandom), 15'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           16'($urandom), 1'b0);
    end

    // WAIT_STATES=3 instance: strobe dropped after two cycles aborts the write.
    drive(1'b1, 15'd9, 15'd9, 1'b1, 16'hDEAD, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("abort_wait", 32'(b3.shr_ack_o), 32'd0);
    end
    b3.shr_stb_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_noack", {15'd0, b3.shr_ack_o, b3.ins_dat_o}, 32'd0);
    end
    drive(1'b1, 15'd0, 15'd0, 1'b0, 16'h0000, 1'b0);
    xfer(1'b1, 15'd9, 15'd9, 1'b0, 16'h0000, 1'b0);

    // Reset during the WAIT cycle of a write: transfer discarded, outputs cleared.
    drive(1'b0, 15'd11, 15'd11, 1'b1, 16'hCAFE, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_ack", 32'(b1.shr_ack_o), 32'd0);
    chk("rstwait_dat", rd_of(1'b0), 32'd0);
    rst = 1'b0;
    xfer(1'b0, 15'd11, 15'd11, 1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
